pg_loader: RTL and testbench

- Receiving end of the MAS16bA programming interface.
- While pg is high, it accepts one 16-bit instruction word per clock from pg_instr and turns the stream into sequential instruction-memory writes starting at address 0.
- It detects the end-of-program word and reports the program length.
- When pg is low, it releases the core to execute through run_en.

---
 rtl/pg_loader.sv | 124 ++++++++++++
 tb/tb_pg_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pg_loader.sv
// Programming-interface receiver: streams pg_instr words into instruction memory
// from address 0 until END_WORD, pg drop or memory full, then gates core execution.
module pg_loader #(
   parameter int          ADDR_W   = 16,
   parameter logic [15:0] END_WORD = 16'hF000
) (
   input  logic              clk,
   input  logic              rstz,
   input  logic              pg,
   input  logic [15:0]       pg_instr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              run_en,
   output logic              load_done,
   output logic              load_abort,
   output logic              overflow,
   output logic [ADDR_W:0]   prog_len
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0]   LEN_ONE = 1;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
   logic              full, full_nxt;
   logic              capture;
   logic              we_nxt, run_nxt, done_nxt, abort_nxt, ovf_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [15:0]       wdata_nxt;
   logic [ADDR_W:0]   len_nxt;

   always_ff @(posedge clk) begin
      if (!rstz) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         full       <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         run_en     <= 1'b0;
         load_done  <= 1'b0;
         load_abort <= 1'b0;
         overflow   <= 1'b0;
         prog_len   <= '0;
      end else begin
         state      <= state_nxt;
         wr_ptr     <= wr_ptr_nxt;
         full       <= full_nxt;
         mem_we     <= we_nxt;
         mem_addr   <= addr_nxt;
         mem_wdata  <= wdata_nxt;
         run_en     <= run_nxt;
         load_done  <= done_nxt;
         load_abort <= abort_nxt;
         overflow   <= ovf_nxt;
         prog_len   <= len_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      wr_ptr_nxt = wr_ptr;
      full_nxt   = full;
      capture    = 1'b0;
      we_nxt     = 1'b0;
      addr_nxt   = mem_addr;
      wdata_nxt  = mem_wdata;
      run_nxt    = run_en;
      done_nxt   = load_done;
      abort_nxt  = load_abort;
      ovf_nxt    = overflow;
      len_nxt    = prog_len;

      case (state)
         IDLE: begin
            if (pg) capture = 1'b1;
            else begin
               state_nxt = RUN;
               run_nxt   = 1'b1;
            end
         end
         LOAD: begin
            if (pg) capture = 1'b1;
            else begin
               state_nxt = DONE;
               abort_nxt = 1'b1;
            end
         end
         RUN: begin
            if (pg) begin
               state_nxt = DONE;
               run_nxt   = 1'b0;
               abort_nxt = 1'b1;
            end
         end
         default: ;
      endcase

      // full means the last location is already written; wr_ptr stays saturated
      if (capture) begin
         if (full) begin
            state_nxt = DONE;
            ovf_nxt   = 1'b1;
         end else begin
            we_nxt    = 1'b1;
            addr_nxt  = wr_ptr;
            wdata_nxt = pg_instr;
            len_nxt   = prog_len + LEN_ONE;
            if (pg_instr == END_WORD) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = LOAD;
               if (&wr_ptr) full_nxt = 1'b1;
               else wr_ptr_nxt = wr_ptr + PTR_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_pg_loader.sv
// Scoreboard bench for pg_loader: two instances (deep and 4-word memory) share one
// stimulus stream; a rule-level model predicts writes, flags, length and run_en.
module tb_pg_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstz = 1'b0;
   logic        pg = 1'b1;
   logic [15:0] pg_instr = '0;

   logic        we_a, run_a, done_a, abort_a, ovf_a;
   logic [15:0] addr_a, wdata_a;
   logic [16:0] len_a;
   logic        we_b, run_b, done_b, abort_b, ovf_b;
   logic [1:0]  addr_b;
   logic [15:0] wdata_b;
   logic [2:0]  len_b;

   pg_loader #(.ADDR_W(16)) u_big (
      .clk(clk), .rstz(rstz), .pg(pg), .pg_instr(pg_instr),
      .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .run_en(run_a),
      .load_done(done_a), .load_abort(abort_a), .overflow(ovf_a), .prog_len(len_a));

   pg_loader #(.ADDR_W(2)) u_small (
      .clk(clk), .rstz(rstz), .pg(pg), .pg_instr(pg_instr),
      .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .run_en(run_b),
      .load_done(done_b), .load_abort(abort_b), .overflow(ovf_b), .prog_len(len_b));

   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   // Reference model: what each loader should be doing, described by phase and word count
   typedef enum {M_IDLE, M_LOADING, M_RUNNING, M_HALTED} mphase_t;
   mphase_t ph[2];
   int      cnt[2];
   int      depth[2];
   bit      e_done[2], e_abort[2], e_ovf[2], e_run[2];
   int      qa0[$], qd0[$], qa1[$], qd1[$];

   initial begin
      depth[0] = 65536;
      depth[1] = 4;
      for (int i = 0; i < 2; i++) begin
         ph[i] = M_IDLE; cnt[i] = 0;
         e_done[i] = 0; e_abort[i] = 0; e_ovf[i] = 0; e_run[i] = 0;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_step(input int i, input bit r, input bit p, input logic [15:0] w);
      bit take;
      take = 1'b0;
      if (!r) begin
         ph[i] = M_IDLE; cnt[i] = 0;
         e_done[i] = 0; e_abort[i] = 0; e_ovf[i] = 0; e_run[i] = 0;
         return;
      end
      case (ph[i])
         M_IDLE:    if (p) take = 1'b1; else begin ph[i] = M_RUNNING; e_run[i] = 1; end
         M_LOADING: if (p) take = 1'b1; else begin ph[i] = M_HALTED; e_abort[i] = 1; end
         M_RUNNING: if (p) begin ph[i] = M_HALTED; e_run[i] = 0; e_abort[i] = 1; end
         default: ;
      endcase
      if (take) begin
         if (cnt[i] == depth[i]) begin
            ph[i] = M_HALTED; e_ovf[i] = 1;
         end else begin
            if (i == 0) begin qa0.push_back(cnt[i]); qd0.push_back(int'(w)); end
            else        begin qa1.push_back(cnt[i]); qd1.push_back(int'(w)); end
            cnt[i]++;
            if (w == 16'hF000) begin ph[i] = M_HALTED; e_done[i] = 1; end
            else ph[i] = M_LOADING;
         end
      end
   endtask

   task automatic check_inst(input int i, input bit we, input int addr, input int data,
                             input bit dn, input bit ab, input bit ov, input bit rn,
                             input int len);
      bit have;
      int ea, ed;
      string t;
      t = (i == 0) ? "big" : "small";
      have = (i == 0) ? (qa0.size() > 0) : (qa1.size() > 0);
      chk({t, ".mem_we"}, int'(we), int'(have));
      if (have) begin
         if (i == 0) begin ea = qa0.pop_front(); ed = qd0.pop_front(); end
         else        begin ea = qa1.pop_front(); ed = qd1.pop_front(); end
         if (we) begin
            chk({t, ".mem_addr"}, addr, ea);
            chk({t, ".mem_wdata"}, data, ed);
         end
      end
      chk({t, ".load_done"}, int'(dn), int'(e_done[i]));
      chk({t, ".load_abort"}, int'(ab), int'(e_abort[i]));
      chk({t, ".overflow"}, int'(ov), int'(e_ovf[i]));
      chk({t, ".run_en"}, int'(rn), int'(e_run[i]));
      chk({t, ".prog_len"}, len, cnt[i]);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check_inst(0, we_a, int'(addr_a), int'(wdata_a), done_a, abort_a, ovf_a, run_a, int'(len_a));
         check_inst(1, we_b, int'(addr_b), int'(wdata_b), done_b, abort_b, ovf_b, run_b, int'(len_b));
      end
   end

   task automatic step(input bit r, input bit p, input logic [15:0] w);
      rstz = r; pg = p; pg_instr = w;
      @(posedge clk);
      model_step(0, r, p, w);
      model_step(1, r, p, w);
      #2;
   endtask

   logic [15:0] prog1 [5] = '{16'h0001, 16'h0502, 16'h0A03, 16'hA000, 16'hF000};

   initial begin
      // full program load, then DONE ignores traffic, then run and illegal pg in RUN
      step(0, 1, 16'h0000);
      mon_en = 1'b1;
      foreach (prog1[k]) step(1, 1, prog1[k]);
      step(1, 1, 16'h5555); step(1, 1, 16'hF000); step(1, 1, 16'h1111);
      step(1, 0, 16'h0000); step(1, 0, 16'hF000);
      step(0, 0, 16'h0000);
      step(1, 0, 16'h0000); step(1, 0, 16'h0000);
      step(1, 1, 16'h2222); step(1, 1, 16'h3333); step(1, 0, 16'h0000);
      // short load aborted by pg drop
      step(0, 1, 16'h0000);
      step(1, 1, 16'h1234); step(1, 1, 16'h5678); step(1, 0, 16'h0000); step(1, 0, 16'h0000);
      // five words, no end marker: the small instance overflows
      step(0, 1, 16'h0000);
      for (int k = 0; k < 5; k++) step(1, 1, 16'h0100 + 16'(k));
      step(1, 1, 16'h0200); step(1, 0, 16'h0000);
      // END_WORD landing exactly in the last small-memory location
      step(0, 1, 16'h0000);
      step(1, 1, 16'h0A0A); step(1, 1, 16'h0B0B); step(1, 1, 16'h0C0C); step(1, 1, 16'hF000);
      step(1, 1, 16'h0D0D);
      // mid-load reset restarts at address 0
      step(0, 1, 16'h0000);
      step(1, 1, 16'h1111); step(1, 1, 16'h2222); step(1, 1, 16'h3333);
      step(0, 1, 16'h4444);
      step(1, 1, 16'hAAAA); step(1, 1, 16'hF000); step(1, 1, 16'h0000);
      // END_WORD as the very first word
      step(0, 1, 16'h0000);
      step(1, 1, 16'hF000); step(1, 0, 16'h0000);
      // randomized traffic
      for (int k = 0; k < 800; k++) begin
         bit          r, p;
         logic [15:0] w;
         r = ($urandom_range(0, 24) != 0);
         p = ($urandom_range(0, 7) != 0);
         w = ($urandom_range(0, 7) == 0) ? 16'hF000 : 16'($urandom);
         step(r, p, w);
      end
      step(1, 0, 16'h0000);
      @(negedge clk);
      #1;
      chk("queue_drain", qa0.size() + qa1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
